// File: rtl/uart_tx_arbiter.sv
// Three-requester, frame-locked arbiter in front of a single UART transmitter.
// Round-robin grant per frame; a stalled locked frame is aborted after TIMEOUT_CYCLES.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [2:0] last,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic [2:0] ack,
  input  logic       tx_rdy,
  output logic       data_wen,
  output logic [7:0] data,
  output logic [1:0] owner,
  output logic       timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, STROBE, POST} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    gnt;
  logic [CW-1:0] cnt;
  logic          last_q;
  logic          own_req;
  logic          own_last;
  logic [7:0]    own_data;

  // Search starts one past the previous winner, so ptr holds the lowest priority.
  always_comb begin
    gnt = 2'd0;
    case (ptr)
      2'd0:    gnt = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    gnt = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: gnt = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = 8'h00;
    case (owner)
      2'd0:    begin own_req = req[0]; own_last = last[0]; own_data = data0; end
      2'd1:    begin own_req = req[1]; own_last = last[1]; own_data = data1; end
      2'd2:    begin own_req = req[2]; own_last = last[2]; own_data = data2; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 2'd3;
      data        <= 8'h00;
      data_wen    <= 1'b1;
      ack         <= 3'b000;
      timeout_err <= 1'b0;
      ptr         <= 2'd2;
      cnt         <= '0;
      last_q      <= 1'b0;
    end else begin
      ack         <= 3'b000;
      timeout_err <= 1'b0;
      data_wen    <= 1'b1;
      case (state)
        IDLE: begin
          if (|req) begin
            owner <= gnt;
            ptr   <= gnt;
            cnt   <= '0;
            state <= WAIT_RDY;
          end else begin
            owner <= 2'd3;
          end
        end
        WAIT_RDY: begin
          // A byte that becomes ready on the final allowed cycle still wins over the abort.
          if (tx_rdy && own_req) begin
            data     <= own_data;
            last_q   <= own_last;
            data_wen <= 1'b0;
            ack      <= 3'b001 << owner;
            state    <= STROBE;
          end else if (cnt == T_LAST) begin
            timeout_err <= 1'b1;
            owner       <= 2'd3;
            cnt         <= T_MAX;
            state       <= IDLE;
          end else if (cnt != T_MAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        STROBE: state <= POST;
        POST: begin
          if (last_q) begin
            owner <= 2'd3;
            state <= IDLE;
          end else begin
            cnt   <= '0;
            state <= WAIT_RDY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
